// File: rtl/pio_pwm_pkg.sv
// Shared definitions for the PIO-driven PWM motor driver.
// Holds the FSM state encoding, command/status field positions and the
// clamped duty-ramp helper.
package pio_pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_REVERSE = 2'd2,
    ST_DEAD    = 2'd3
  } state_t;

  localparam int unsigned DUTY_W = 12;

  localparam logic [3:0] CMD_TAG = 4'h5;

  // command word fields
  localparam int unsigned CMD_TAG_MSB  = 31;
  localparam int unsigned CMD_TAG_LSB  = 28;
  localparam int unsigned CMD_EN_BIT   = 27;
  localparam int unsigned CMD_DIR_BIT  = 26;
  localparam int unsigned CMD_DUTY_MSB = 23;
  localparam int unsigned CMD_DUTY_LSB = 12;

  // status word fields
  localparam int unsigned ST_DUTY_MSB  = 31;
  localparam int unsigned ST_DUTY_LSB  = 20;
  localparam int unsigned ST_DIR_BIT   = 19;
  localparam int unsigned ST_EN_BIT    = 18;
  localparam int unsigned ST_STATE_MSB = 17;
  localparam int unsigned ST_STATE_LSB = 16;
  localparam int unsigned ST_REJ_MSB   = 15;
  localparam int unsigned ST_REJ_LSB   = 8;
  localparam int unsigned ST_ACC_MSB   = 7;
  localparam int unsigned ST_ACC_LSB   = 0;

  // Move cur toward tgt by at most step. One extra bit of headroom keeps
  // the sum from wrapping; the result is clamped to tgt so it never overshoots.
  function automatic logic [DUTY_W-1:0] ramp_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W:0]   step
  );
    logic [DUTY_W:0] cur_x;
    logic [DUTY_W:0] tgt_x;
    logic [DUTY_W:0] sum;
    logic [DUTY_W:0] diff;
    logic [DUTY_W:0] sub;
    cur_x = {1'b0, cur};
    tgt_x = {1'b0, tgt};
    sum   = cur_x + step;
    diff  = cur_x - tgt_x;
    sub   = cur_x - step;
    if (cur_x < tgt_x) begin
      ramp_toward = (sum > tgt_x) ? tgt : sum[DUTY_W-1:0];
    end else begin
      ramp_toward = (diff > step) ? sub[DUTY_W-1:0] : tgt;
    end
  endfunction

endpackage

// File: rtl/pio_pwm_driver_timebase.sv
// PWM timebase: prescaler plus free-running 12-bit period counter.
//   i_clk        system clock
//   i_reset      synchronous active-high reset
//   o_pwm_cnt    current PWM counter value (0..4095)
//   o_tick       high on the last prescaler cycle of each counter step
//   o_period_end high on the tick that wraps the counter 4095 -> 0
module pio_pwm_timebase
  import pio_pwm_pkg::*;
#(
  parameter int unsigned PRESCALE = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic [DUTY_W-1:0] o_pwm_cnt,
  output logic              o_tick,
  output logic              o_period_end
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]  r_pre;
  logic [DUTY_W-1:0] r_cnt;
  logic              w_tick;

  assign w_tick = (r_pre == PRE_MAX);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pwm_cnt    = r_cnt;
  assign o_tick       = w_tick;
  assign o_period_end = w_tick && (r_cnt == '1);

endmodule

// File: rtl/pio_pwm_driver.sv
// PIO command decoder and PWM/direction driver with soft ramping and a
// dead-time sequence on direction reversal.
//   clk       system clock
//   reset     synchronous active-high reset
//   cmd_word  command word from the PIO output port
//   pwm_out   registered PWM drive
//   dir_out   active direction
//   status    registered status word for the PIO input port
module pio_pwm_driver
  import pio_pwm_pkg::*;
#(
  parameter int unsigned PRESCALE  = 4,
  parameter int unsigned RAMP_STEP = 64,
  parameter int unsigned DEADTIME  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cmd_word,
  output logic        pwm_out,
  output logic        dir_out,
  output logic [31:0] status
);

  localparam logic [DUTY_W:0] STEP_X = RAMP_STEP[DUTY_W:0];
  localparam int unsigned DC_W = $clog2(DEADTIME + 1);
  localparam logic [DC_W-1:0] DEAD_LOAD = DC_W'(DEADTIME);
  localparam logic [DC_W-1:0] DEAD_ONE  = DC_W'(1);

  logic [31:0]       r_cmd_q;
  logic [31:0]       r_cmd_last;
  logic              r_req_en;
  logic              r_req_dir;
  logic [DUTY_W-1:0] r_req_duty;
  logic [7:0]        r_acc_cnt;
  logic [7:0]        r_rej_cnt;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [DUTY_W-1:0] r_duty_cur;
  logic              r_dir_active;
  logic [DC_W-1:0]   r_dead_cnt;
  logic              r_pwm;
  logic [31:0]       r_status;
  logic [31:0]       w_status;
  logic [DUTY_W-1:0] w_eff_target;
  logic [DUTY_W-1:0] w_pwm_cnt;
  logic              w_tick_unused;
  logic              w_period_end;

  pio_pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .i_clk        (clk),
    .i_reset      (reset),
    .o_pwm_cnt    (w_pwm_cnt),
    .o_tick       (w_tick_unused),
    .o_period_end (w_period_end)
  );

  // Command capture: only a change of the registered word is acted upon.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_q    <= '0;
      r_cmd_last <= '0;
      r_req_en   <= 1'b0;
      r_req_dir  <= 1'b0;
      r_req_duty <= '0;
      r_acc_cnt  <= '0;
      r_rej_cnt  <= '0;
    end else begin
      r_cmd_q <= cmd_word;
      if (r_cmd_q != r_cmd_last) begin
        r_cmd_last <= r_cmd_q;
        if (r_cmd_q[CMD_TAG_MSB:CMD_TAG_LSB] == CMD_TAG) begin
          r_req_en   <= r_cmd_q[CMD_EN_BIT];
          r_req_dir  <= r_cmd_q[CMD_DIR_BIT];
          r_req_duty <= r_cmd_q[CMD_DUTY_MSB:CMD_DUTY_LSB];
          r_acc_cnt  <= r_acc_cnt + 8'd1;
        end else if (r_rej_cnt != '1) begin
          r_rej_cnt <= r_rej_cnt + 8'd1;
        end
      end
    end
  end

  assign w_eff_target = ((r_state == ST_REVERSE) || !r_req_en) ? '0 : r_req_duty;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_req_en && (r_req_duty != '0)) begin
          w_state_nxt = (r_req_dir != r_dir_active) ? ST_DEAD : ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_req_dir != r_dir_active) begin
          w_state_nxt = ST_REVERSE;
        end else if ((r_duty_cur == '0) && !r_req_en) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REVERSE: begin
        if (r_req_dir == r_dir_active) begin
          w_state_nxt = ST_RUN;
        end else if (w_period_end && (r_duty_cur == '0)) begin
          w_state_nxt = ST_DEAD;
        end
      end
      ST_DEAD: begin
        // The final decrement and the exit share one period_end so DEAD
        // spans exactly DEADTIME whole periods.
        if (w_period_end && (r_dead_cnt <= DEAD_ONE)) begin
          w_state_nxt = r_req_en ? ST_RUN : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_duty_cur   <= '0;
      r_dir_active <= 1'b0;
      r_dead_cnt   <= '0;
      r_pwm        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state != ST_DEAD) && (w_state_nxt == ST_DEAD)) begin
        r_dead_cnt <= DEAD_LOAD;
      end else if ((r_state == ST_DEAD) && w_period_end && (r_dead_cnt != '0)) begin
        r_dead_cnt <= r_dead_cnt - 1'b1;
      end

      if ((r_state == ST_DEAD) && (w_state_nxt != ST_DEAD)) begin
        r_dir_active <= r_req_dir;
      end

      if (w_period_end && (r_state != ST_DEAD)) begin
        r_duty_cur <= ramp_toward(r_duty_cur, w_eff_target, STEP_X);
      end

      r_pwm <= (w_pwm_cnt < r_duty_cur) && (r_state == ST_RUN);
    end
  end

  always_comb begin
    w_status = '0;
    w_status[ST_DUTY_MSB:ST_DUTY_LSB]   = r_duty_cur;
    w_status[ST_DIR_BIT]                = r_dir_active;
    w_status[ST_EN_BIT]                 = r_req_en;
    w_status[ST_STATE_MSB:ST_STATE_LSB] = r_state;
    w_status[ST_REJ_MSB:ST_REJ_LSB]     = r_rej_cnt;
    w_status[ST_ACC_MSB:ST_ACC_LSB]     = r_acc_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_status <= '0;
    end else begin
      r_status <= w_status;
    end
  end

  assign pwm_out = r_pwm;
  assign dir_out = r_dir_active;
  assign status  = r_status;

endmodule
